complex_alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one Comlex_ALU instance between two requesters.
- Accepts one operation at a time, issues it to the ALU with the start/a_valid/b_valid handshake, and waits for valid or error.
- Returns the 48-bit result, tagged with the requester ID.
- Sits between the two client blocks and the ALU.

---
 rtl/complex_alu_arbiter_if.sv | 48 ++++
 rtl/complex_alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_complex_alu_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_alu_arbiter_if.sv
// Bundle of the client-side and ALU-side signals of complex_alu_arbiter.
// slave  : the arbiter's view (drives grants, ALU controls, responses).
// master : the environment's view (clients plus ALU).
interface complex_alu_arbiter_if #(
  parameter int DW = 16,
  parameter int RW = 48
);
  logic          req0;
  logic [1:0]    op0;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic          gnt0;
  logic          req1;
  logic [1:0]    op1;
  logic [DW-1:0] a1;
  logic [DW-1:0] b1;
  logic          gnt1;
  logic [1:0]    alu_operation;
  logic          alu_start;
  logic          alu_a_valid;
  logic          alu_b_valid;
  logic [DW-1:0] alu_m1;
  logic [DW-1:0] alu_m2;
  logic          alu_valid;
  logic          alu_error;
  logic [RW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_id;
  logic          rsp_error;
  logic [RW-1:0] rsp_result;
  logic          busy;

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    input  alu_valid, alu_error, alu_result,
    output gnt0, gnt1,
    output alu_operation, alu_start, alu_a_valid, alu_b_valid, alu_m1, alu_m2,
    output rsp_valid, rsp_id, rsp_error, rsp_result, busy
  );

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    output alu_valid, alu_error, alu_result,
    input  gnt0, gnt1,
    input  alu_operation, alu_start, alu_a_valid, alu_b_valid, alu_m1, alu_m2,
    input  rsp_valid, rsp_id, rsp_error, rsp_result, busy
  );
endinterface

// File: rtl/complex_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one complex ALU between two clients.
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional WAIT watchdog: define COMPLEX_ALU_ARB_TIMEOUT_EN to enable it;
// after TIMEOUT cycles in WAIT an error response with a zero result is sent.
module complex_alu_arbiter #(
  parameter int DW      = 16,
  parameter int RW      = 48,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  complex_alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic          last_reg, last_next;    // requester served most recently
  logic          id_reg, id_next;        // requester of the operation in flight
  logic [1:0]    op_reg, op_next;        // doubles as the op capture register
  logic [DW-1:0] m1_reg, m1_next;
  logic [DW-1:0] m2_reg, m2_next;
  logic          start_reg, start_next;
  logic          gnt0_reg, gnt0_next;
  logic          gnt1_reg, gnt1_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic          rsp_id_reg, rsp_id_next;
  logic          rsp_error_reg, rsp_error_next;
  logic [RW-1:0] rsp_result_reg, rsp_result_next;
  logic          busy_reg, busy_next;
  logic          pick0;

`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Requester 0 wins when alone, or on a tie when requester 1 was served last.
  assign pick0 = bus.req0 && (!bus.req1 || last_reg);

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_next      = state_reg;
    last_next       = last_reg;
    id_next         = id_reg;
    op_next         = op_reg;
    m1_next         = m1_reg;
    m2_next         = m2_reg;
    start_next      = 1'b0;
    gnt0_next       = 1'b0;
    gnt1_next       = 1'b0;
    rsp_valid_next  = 1'b0;
    rsp_id_next     = rsp_id_reg;
    rsp_error_next  = rsp_error_reg;
    rsp_result_next = rsp_result_reg;
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          id_next    = !pick0;
          op_next    = pick0 ? bus.op0 : bus.op1;
          m1_next    = pick0 ? bus.a0 : bus.a1;
          m2_next    = pick0 ? bus.b0 : bus.b1;
          gnt0_next  = pick0;
          gnt1_next  = !pick0;
          start_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.alu_valid || bus.alu_error) begin
          rsp_result_next = bus.alu_result;
          rsp_error_next  = bus.alu_error;
          rsp_id_next     = id_reg;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
        else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          rsp_result_next = '0;
          rsp_error_next  = 1'b1;
          rsp_id_next     = id_reg;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        last_next  = rsp_id_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_reg       <= 1'b1;
      id_reg         <= 1'b0;
      op_reg         <= '0;
      m1_reg         <= '0;
      m2_reg         <= '0;
      start_reg      <= 1'b0;
      gnt0_reg       <= 1'b0;
      gnt1_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_error_reg  <= 1'b0;
      rsp_result_reg <= '0;
      busy_reg       <= 1'b0;
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      last_reg       <= last_next;
      id_reg         <= id_next;
      op_reg         <= op_next;
      m1_reg         <= m1_next;
      m2_reg         <= m2_next;
      start_reg      <= start_next;
      gnt0_reg       <= gnt0_next;
      gnt1_reg       <= gnt1_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_error_reg  <= rsp_error_next;
      rsp_result_reg <= rsp_result_next;
      busy_reg       <= busy_next;
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
`endif
    end
  end

  assign bus.gnt0          = gnt0_reg;
  assign bus.gnt1          = gnt1_reg;
  assign bus.alu_operation = op_reg;
  assign bus.alu_start     = start_reg;
  assign bus.alu_a_valid   = start_reg;
  assign bus.alu_b_valid   = start_reg;
  assign bus.alu_m1        = m1_reg;
  assign bus.alu_m2        = m2_reg;
  assign bus.rsp_valid     = rsp_valid_reg;
  assign bus.rsp_id        = rsp_id_reg;
  assign bus.rsp_error     = rsp_error_reg;
  assign bus.rsp_result    = rsp_result_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_complex_alu_arbiter.sv
// Self-checking bench for complex_alu_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized phase checked
// against a round-robin reference model. Includes a small ALU model.
module tb_complex_alu_arbiter;

  localparam int DW = 16;
  localparam int RW = 48;
  localparam int TO = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  complex_alu_arbiter_if #(.DW(DW), .RW(RW)) bus ();

  complex_alu_arbiter #(.DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  int          alu_lat  = 1;      // cycles after start; 0 = never answer
  bit          alu_fn   = 1'b0;   // 1: answer computed from operands
  bit          alu_spur = 1'b0;   // pulse a bogus valid during the start cycle
  logic [47:0] alu_fix_res = '0;
  bit          alu_fix_v = 1'b0;
  bit          alu_fix_e = 1'b0;
  int          alu_cnt;
  bit          alu_pend;
  logic [47:0] pend_res;
  bit          pend_v, pend_e;

  function automatic logic [47:0] res_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    return {op, 14'h2a5, a ^ b, a};
  endfunction

  function automatic bit err_fn(input logic [1:0] op, input logic [15:0] a);
    return (op == 2'd3) && a[0];
  endfunction

  initial begin
    bus.alu_valid  = 1'b0;
    bus.alu_error  = 1'b0;
    bus.alu_result = '0;
    alu_pend = 1'b0;
    alu_cnt  = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        bus.alu_valid = 1'b0;
        bus.alu_error = 1'b0;
        alu_pend      = 1'b0;
      end else begin
        bus.alu_valid = 1'b0;
        bus.alu_error = 1'b0;
        if (bus.alu_start) begin
          if (alu_fn) begin
            pend_res = res_fn(bus.alu_operation, bus.alu_m1, bus.alu_m2);
            pend_e   = err_fn(bus.alu_operation, bus.alu_m1);
            pend_v   = !pend_e || bus.alu_m1[1];
          end else begin
            pend_res = alu_fix_res;
            pend_v   = alu_fix_v;
            pend_e   = alu_fix_e;
          end
          alu_cnt  = alu_lat;
          alu_pend = (alu_lat != 0);
          if (alu_spur) begin
            bus.alu_valid  = 1'b1;
            bus.alu_result = 48'hdead_beef_0bad;
          end
        end else if (alu_pend) begin
          alu_cnt--;
          if (alu_cnt == 0) begin
            bus.alu_valid  = pend_v;
            bus.alu_error  = pend_e;
            bus.alu_result = pend_res;
            alu_pend       = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired, expected event never seen", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, output logic [1:0] g);
    g = 2'b00;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (bus.gnt0 || bus.gnt1) begin
        g = {bus.gnt1, bus.gnt0};
        break;
      end
    end
    if (g == 2'b00) fail_now({tag, "_gnt"});
  endtask

  task automatic wait_rsp(input string tag, input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.rsp_valid && n < maxc);
    if (!bus.rsp_valid) fail_now({tag, "_rsp"});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          id;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    bit          spur;
    logic [47:0] res;
    bit          v;
    bit          e;
    bit          exp_err;
    logic [47:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  task automatic run_txn(input vec_t v, input int idx);
    logic [1:0] g;
    int n;
    @(negedge clk);
    alu_fn = 1'b0; alu_lat = v.lat; alu_spur = v.spur;
    alu_fix_res = v.res; alu_fix_v = v.v; alu_fix_e = v.e;
    if (v.id) begin
      bus.req1 = 1'b1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b;
    end else begin
      bus.req0 = 1'b1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b;
    end
    wait_gnt($sformatf("vec%0d", idx), g);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (g == 2'b00) return;
    chk($sformatf("vec%0d_gnt", idx), g, v.id ? 2'b10 : 2'b01);
    chk($sformatf("vec%0d_issue_strobes", idx), {bus.alu_start, bus.alu_a_valid, bus.alu_b_valid}, 3'b111);
    chk($sformatf("vec%0d_issue_bus", idx), {bus.alu_operation, bus.alu_m1, bus.alu_m2}, {v.op, v.a, v.b});
    @(posedge clk); #1;
    chk($sformatf("vec%0d_wait_strobes", idx),
        {bus.alu_start, bus.alu_a_valid, bus.alu_b_valid, bus.gnt0, bus.gnt1, bus.rsp_valid}, 6'b0);
    chk($sformatf("vec%0d_wait_busy", idx), bus.busy, 1'b1);
    wait_rsp($sformatf("vec%0d", idx), 40, n);
    chk($sformatf("vec%0d_latency", idx), n, v.lat);
    chk($sformatf("vec%0d_rsp", idx), {bus.rsp_id, bus.rsp_error, bus.rsp_result}, {v.id, v.exp_err, v.exp_res});
    chk($sformatf("vec%0d_op_held", idx), {bus.alu_operation, bus.alu_m1, bus.alu_m2}, {v.op, v.a, v.b});
    @(posedge clk); #1;
    chk($sformatf("vec%0d_after_rsp", idx),
        {bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_error, bus.rsp_result},
        {2'b00, v.id, v.exp_err, v.exp_res});
  endtask

  // ---------------- random-phase reference model ----------------
  typedef struct {
    bit          id;
    bit          err;
    logic [47:0] res;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    logic [1:0]  g;
    int          n, run, nrsp, served;
    bit          seen, last, inflight, w;
    logic [1:0]  wop;
    logic [15:0] wa, wb;
    int          gq[$], oq[$], rq[$];
    exp_t        e;

    rst = 1'b1;
    bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;

    vecs[0] = '{id:1'b0, op:2'd0, a:16'h0003, b:16'h0004, lat:5, spur:1'b0,
                res:48'h7, v:1'b1, e:1'b0, exp_err:1'b0, exp_res:48'h7};
    vecs[1] = '{id:1'b1, op:2'd3, a:16'h00f0, b:16'h0f00, lat:2, spur:1'b0,
                res:48'h123, v:1'b1, e:1'b1, exp_err:1'b1, exp_res:48'h123};
    vecs[2] = '{id:1'b0, op:2'd2, a:16'hffff, b:16'h0001, lat:1, spur:1'b1,
                res:48'habc, v:1'b0, e:1'b1, exp_err:1'b1, exp_res:48'habc};
    vecs[3] = '{id:1'b1, op:2'd1, a:16'h8000, b:16'h7fff, lat:3, spur:1'b0,
                res:48'hffff_ffff_ffff, v:1'b1, e:1'b0, exp_err:1'b0, exp_res:48'hffff_ffff_ffff};
    vecs[4] = '{id:1'b0, op:2'd3, a:16'h5a5a, b:16'ha5a5, lat:4, spur:1'b1,
                res:48'h0, v:1'b1, e:1'b0, exp_err:1'b0, exp_res:48'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {bus.gnt0, bus.gnt1, bus.alu_start, bus.alu_a_valid, bus.alu_b_valid,
                       bus.alu_operation, bus.rsp_valid, bus.rsp_id, bus.rsp_error, bus.busy}, 0);
    chk("reset_data", {bus.alu_m1, bus.alu_m2}, 0);
    chk("reset_result", bus.rsp_result, 0);
    rst = 1'b0;

    // Directed single transactions
    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Both requesters held from reset: grants alternate starting with 0
    bus.req0 = 1'b1; bus.op0 = 2'd1; bus.a0 = 16'h0011; bus.b0 = 16'h0022;
    bus.req1 = 1'b1; bus.op1 = 2'd2; bus.a1 = 16'h0033; bus.b1 = 16'h0044;
    alu_fn = 1'b1; alu_lat = 2; alu_spur = 1'b0;
    do_reset();
    run = 0; nrsp = 0;
    for (int c = 0; c < 200 && nrsp < 4; c++) begin
      @(posedge clk); #1;
      if (bus.gnt0 || bus.gnt1) begin
        chk("both_gnt_onehot", bus.gnt0 & bus.gnt1, 1'b0);
        gq.push_back(int'(bus.gnt1));
        oq.push_back(int'(bus.alu_operation));
      end
      if (bus.rsp_valid) begin
        rq.push_back(int'(bus.rsp_id));
        nrsp++;
      end
      if (!bus.busy) run++;
      else if (run > 0) begin
        chk("both_idle_run", run, 1);
        run = 0;
      end
    end
    chk("both_rsp_count", nrsp, 4);
    for (int i = 0; i < 4 && i < gq.size() && i < rq.size(); i++) begin
      chk($sformatf("both_gnt%0d", i), gq[i], i % 2);
      chk($sformatf("both_op%0d", i), oq[i], (i % 2 == 1) ? 2 : 1);
      chk($sformatf("both_rspid%0d", i), rq[i], i % 2);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset in WAIT, then pending req1 and a tie
    alu_fn = 1'b0; alu_lat = 0;
    bus.req0 = 1'b1; bus.op0 = 2'd3; bus.a0 = 16'h1234; bus.b0 = 16'h5678;
    wait_gnt("rstwait", g);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.op1 = 2'd2; bus.a1 = 16'h0abc; bus.b1 = 16'h0def;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {bus.gnt0, bus.gnt1, bus.alu_start, bus.alu_a_valid, bus.alu_b_valid,
                           bus.alu_operation, bus.rsp_valid, bus.rsp_id, bus.rsp_error, bus.busy}, 0);
    chk("async_rst_data", {bus.alu_m1, bus.alu_m2}, 0);
    chk("async_rst_result", bus.rsp_result, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    alu_fn = 1'b1; alu_lat = 2;
    wait_gnt("rst_req1", g);
    chk("rst_req1_gnt", g, 2'b10);
    bus.req1 = 1'b0;
    wait_rsp("rst_req1", 40, n);
    chk("rst_req1_rsp", {bus.rsp_id, bus.rsp_error, bus.rsp_result}, {1'b1, 1'b0, res_fn(2'd2, 16'h0abc, 16'h0def)});
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = 2'd0; bus.a0 = 16'h0001; bus.b0 = 16'h0002;
    bus.req1 = 1'b1;
    wait_gnt("tie", g);
    chk("tie_gnt", g, 2'b01);
    bus.req0 = 1'b0;
    wait_rsp("tie0", 40, n);
    wait_gnt("tie_next", g);
    chk("tie_next_gnt", g, 2'b10);
    bus.req1 = 1'b0;
    wait_rsp("tie1", 40, n);
    chk("tie1_rsp_id", bus.rsp_id, 1'b1);
    repeat (3) @(negedge clk);

    // ALU that never answers
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
    alu_fn = 1'b0; alu_lat = 12; alu_fix_res = 48'hbeef; alu_fix_v = 1'b1; alu_fix_e = 1'b0;
`else
    alu_fn = 1'b0; alu_lat = 0;
`endif
    bus.req0 = 1'b1; bus.op0 = 2'd1; bus.a0 = 16'h0007; bus.b0 = 16'h0009;
    wait_gnt("noans", g);
    bus.req0 = 1'b0;
`ifdef COMPLEX_ALU_ARB_TIMEOUT_EN
    wait_rsp("timeout", 40, n);
    chk("timeout_latency", n, TO + 1);
    chk("timeout_rsp", {bus.rsp_id, bus.rsp_error, bus.rsp_result}, {1'b0, 1'b1, 48'h0});
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || bus.busy) seen = 1'b1;
    end
    chk("late_alu_ignored", seen, 1'b0);
`else
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || !bus.busy) seen = 1'b1;
    end
    chk("noans_stuck", seen, 1'b0);
    chk("noans_busy", bus.busy, 1'b1);
`endif

    // Randomized traffic against the round-robin model
    alu_fn = 1'b1; alu_lat = 1; alu_spur = 1'b0;
    do_reset();
    last = 1'b1; inflight = 1'b0; served = 0;
    for (int c = 0; c < 3000 && served < 30; c++) begin
      @(negedge clk);
      alu_lat = $urandom_range(1, 4);
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1; bus.op0 = 2'($urandom_range(0, 3));
        bus.a0 = 16'($urandom); bus.b0 = 16'($urandom);
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1; bus.op1 = 2'($urandom_range(0, 3));
        bus.a1 = 16'($urandom); bus.b1 = 16'($urandom);
      end
      @(posedge clk); #1;
      if (bus.gnt0 || bus.gnt1) begin
        // Winner: the one not served last if both wait, else the lone waiter.
        if (bus.req0 && bus.req1) w = (last == 1'b1) ? 1'b0 : 1'b1;
        else                      w = bus.req1;
        chk("rnd_overlap", inflight, 1'b0);
        chk("rnd_gnt", {bus.gnt1, bus.gnt0}, w ? 2'b10 : 2'b01);
        wop = w ? bus.op1 : bus.op0;
        wa  = w ? bus.a1 : bus.a0;
        wb  = w ? bus.b1 : bus.b0;
        chk("rnd_issue_bus", {bus.alu_operation, bus.alu_m1, bus.alu_m2}, {wop, wa, wb});
        exp_q.push_back('{id:w, err:err_fn(wop, wa), res:res_fn(wop, wa, wb)});
        inflight = 1'b1;
        if (w) bus.req1 = 1'b0;
        else   bus.req0 = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) fail_now("rnd_unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          chk("rnd_rsp", {bus.rsp_id, bus.rsp_error, bus.rsp_result}, {e.id, e.err, e.res});
          last = e.id;
        end
        inflight = 1'b0;
        served++;
      end
    end
    chk("rnd_served", served, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
